mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the instruction-fetch path (IF stage, PC address) and the data path (MEM stage, ALU address with read/write).
- Data accesses have fixed priority because they belong to the older instruction.
- Produces per-requester completion strobes and one pipeline stall.
- Sits between the pipelined CPU core and the memory model; a watchdog bounds every memory transaction.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data/instruction width.
- MAX_WAIT, 16, cycles a memory transaction may stay outstanding before it is aborted (1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_valid.
- if_addr  in  ADDR_W  fetch address (PC).
- if_valid  out  1  fetch complete this cycle.
- if_rdata  out  DATA_W  fetched instruction; valid with if_valid, held until next completion.
- d_req  in  1  data request (mem_r|mem_w), level, held until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  data access complete this cycle.
- d_rdata  out  DATA_W  load data; valid with d_done, held afterwards.
- stall  out  1  (if_req & ~if_valid) | (d_req & ~d_done).
- err  out  1  one-cycle pulse on watchdog abort.
- m_req  out  1  memory request, held until m_ready or abort.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address, registered.
- m_wdata  out  DATA_W  memory write data, registered.
- m_ready  in  1  memory completes the current transaction this cycle; m_rdata valid.
- m_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - m_req, m_we, if_valid, d_done, err = 0.
  - m_addr, m_wdata, if_rdata, d_rdata = 0.
  - Wait counter = 0.
  - A reset mid-transaction abandons it immediately; m_req drops without waiting for m_ready.
- FSM states: IDLE, DATA, FETCH.
- IDLE:
  - If d_req: latch d_addr/d_we/d_wdata into m_*; go to DATA.
  - Else if if_req: latch if_addr and m_we=0; go to FETCH.
  - Else stay. m_req=0.
  - Simultaneous d_req and if_req: data wins; fetch waits and stall stays high.
- DATA/FETCH:
  - m_req=1; m_addr, m_we, m_wdata stable.
  - m_ready may assert in the first DATA/FETCH cycle.
  - On m_ready: d_done (DATA) or if_valid (FETCH) is asserted combinationally in the same cycle with m_rdata passed through. m_rdata is also registered into d_rdata/if_rdata. Next state IDLE.
- Minimum latency: request sampled in IDLE at cycle 0, completion at cycle 1. Back-to-back accesses cost 2 cycles each.
- A requester must deassert or change its request at the edge following its strobe. IDLE re-samples requests, so a held request is treated as a new access.
- A request dropped mid-transaction is a protocol violation. The transaction still completes and the strobe is still generated.
- Watchdog:
  - Counter clears on entry to DATA/FETCH and increments each cycle without m_ready.
  - When the count reaches MAX_WAIT-1 without m_ready: abort. err=1 and the strobe of the owning requester=1 for one cycle, rdata forced to 0, m_req=0 next cycle, state IDLE.
  - m_ready in the abort cycle wins: normal completion, no err.
- Writes return no data; d_rdata is unchanged on a write completion.
- stall is purely combinational from current requests and strobes.

Optional Feature:
- MEM_ARB_FBUF_EN: one-entry fetch buffer (tag = address, valid bit, instruction).
- With the macro:
  - Each completed non-aborted fetch loads the buffer.
  - In IDLE with if_req, no d_req, valid=1 and if_addr==tag: if_valid=1 in the same cycle with the buffered instruction; no memory access; state stays IDLE.
  - Any completed data write invalidates the buffer. Reset invalidates it.
- Without the macro: every fetch goes to memory; no buffer registers exist.

Test Plan:
- Fetch only, if_addr=0x00000010, m_ready 1 cycle after m_req -> m_addr=0x10, m_we=0, if_valid at cycle 2, if_rdata=0x00500093, stall high cycles 0-1.
- Simultaneous if_req (0x14) and d_req read (0x100), m_ready immediate -> data first (d_done cycle 1, d_rdata=0xDEADBEEF), then fetch (if_valid cycle 3); stall high through cycle 2.
- Store d_we=1, d_addr=0x200, d_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678 held until m_ready (3-cycle wait); d_done with m_ready; d_rdata unchanged.
- MAX_WAIT=4, m_ready never asserted -> err and d_done pulse at 4th DATA cycle, d_rdata=0, m_req low next cycle, state IDLE.
- Reset asserted low in the 2nd FETCH cycle -> m_req=0 and if_valid=0 immediately (asynchronous); after release with if_req still high, a new fetch starts from IDLE.
- MEM_ARB_FBUF_EN: fetch 0x20 twice -> second fetch gives if_valid same cycle with no m_req. Store to 0x300, then fetch 0x20 -> memory access reissued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between instruction fetch and data access.
// Optional one-entry fetch buffer enabled by defining MEM_ARB_FBUF_EN.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FETCH} state_t;

    localparam logic [7:0] WD_LIMIT = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [7:0]        wait_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic busy;
    logic timeout;
    logic fin;
    logic fbuf_hit;

    assign busy    = (state_q != ST_IDLE);
    // m_ready in the last allowed cycle takes precedence over the abort
    assign timeout = busy && !m_ready && (wait_q == WD_LIMIT);
    assign fin     = busy && (m_ready || timeout);

`ifdef MEM_ARB_FBUF_EN
    logic              fbuf_valid_q;
    logic [ADDR_W-1:0] fbuf_tag_q;
    logic [DATA_W-1:0] fbuf_data_q;

    assign fbuf_hit = (state_q == ST_IDLE) && if_req && !d_req && fbuf_valid_q
                      && (if_addr == fbuf_tag_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fbuf_valid_q <= 1'b0;
            fbuf_tag_q   <= '0;
            fbuf_data_q  <= '0;
        end else if (state_q == ST_FETCH && m_ready) begin
            fbuf_valid_q <= 1'b1;
            fbuf_tag_q   <= m_addr_q;
            fbuf_data_q  <= m_rdata;
        end else if (state_q == ST_DATA && fin && m_we_q) begin
            fbuf_valid_q <= 1'b0;
        end
    end
`else
    assign fbuf_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: data belongs to the older instruction, so it wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (d_req) begin
                    state_d = ST_DATA;
                end else if (if_req && !fbuf_hit) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DATA, ST_FETCH: begin
                if (fin) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        m_req    = busy;
        err      = timeout;
        d_done   = (state_q == ST_DATA) && fin;
        if_valid = ((state_q == ST_FETCH) && fin) || fbuf_hit;
        d_rdata  = d_rdata_q;
        if_rdata = if_rdata_q;
        if (state_q == ST_DATA) begin
            if (timeout) begin
                d_rdata = '0;
            end else if (m_ready && !m_we_q) begin
                d_rdata = m_rdata;
            end
        end
        if (state_q == ST_FETCH) begin
            if (timeout) begin
                if_rdata = '0;
            end else if (m_ready) begin
                if_rdata = m_rdata;
            end
        end
`ifdef MEM_ARB_FBUF_EN
        if (fbuf_hit) begin
            if_rdata = fbuf_data_q;
        end
`endif
        stall = (if_req && !if_valid) || (d_req && !d_done);
    end

    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

    // Memory-side command registers, captured when leaving IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (state_d == ST_DATA) begin
                m_we_q    <= d_we;
                m_addr_q  <= d_addr;
                m_wdata_q <= d_wdata;
            end else if (state_d == ST_FETCH) begin
                m_we_q    <= 1'b0;
                m_addr_q  <= if_addr;
            end
        end
    end

    // Read-data holding registers simply track the combinational outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else if (state_q == ST_IDLE) begin
            wait_q <= '0;
        end else if (!m_ready) begin
            wait_q <= wait_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_WAIT=4); fetch-buffer expectations follow MEM_ARB_FBUF_EN.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        stall;
    logic        err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .stall(stall), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_ready = 0; m_rdata = 0;
        repeat (2) next_cycle();
        #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_mreq: got %0b want 0", m_req); end
        checks++; if (m_we !== 1'b0 || err !== 1'b0 || if_valid !== 1'b0 || d_done !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: m_we=%0b err=%0b if_valid=%0b d_done=%0b want all 0", m_we, err, if_valid, d_done); end
        checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: m_addr=%h m_wdata=%h if_rdata=%h d_rdata=%h want 0", m_addr, m_wdata, if_rdata, d_rdata); end
        next_cycle();
        rst = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_fetch();
        next_cycle(); if_req = 1; if_addr = 32'h10; #1;
        checks++; if (stall !== 1'b1 || m_req !== 1'b0) begin errors++; $display("FAIL fetch_c0: stall=%0b m_req=%0b want 1/0", stall, m_req); end
        next_cycle(); #1;
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h10 || m_we !== 1'b0) begin
            errors++; $display("FAIL fetch_c1_cmd: m_req=%0b m_addr=%h m_we=%0b want 1/10/0", m_req, m_addr, m_we); end
        checks++; if (if_valid !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL fetch_c1_wait: if_valid=%0b stall=%0b want 0/1", if_valid, stall); end
        next_cycle(); m_ready = 1; m_rdata = 32'h00500093; #1;
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00500093 || stall !== 1'b0) begin
            errors++; $display("FAIL fetch_c2_done: if_valid=%0b if_rdata=%h stall=%0b want 1/00500093/0", if_valid, if_rdata, stall); end
        next_cycle(); if_req = 0; m_ready = 0; m_rdata = 32'hAAAAAAAA; #1;
        checks++; if (m_req !== 1'b0 || if_valid !== 1'b0 || if_rdata !== 32'h00500093) begin
            errors++; $display("FAIL fetch_c3_hold: m_req=%0b if_valid=%0b if_rdata=%h want 0/0/00500093", m_req, if_valid, if_rdata); end
        $display("fetch: addr=0x10 instr=%h", if_rdata);
    endtask

    task automatic test_priority();
        next_cycle(); if_req = 1; if_addr = 32'h14; d_req = 1; d_we = 0; d_addr = 32'h100; #1;
        checks++; if (stall !== 1'b1 || m_req !== 1'b0) begin errors++; $display("FAIL prio_c0: stall=%0b m_req=%0b want 1/0", stall, m_req); end
        next_cycle(); m_ready = 1; m_rdata = 32'hDEADBEEF; #1;
        checks++; if (m_addr !== 32'h100 || m_we !== 1'b0) begin errors++; $display("FAIL prio_c1_addr: m_addr=%h m_we=%0b want 100/0", m_addr, m_we); end
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hDEADBEEF || if_valid !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL prio_c1_done: d_done=%0b d_rdata=%h if_valid=%0b stall=%0b want 1/deadbeef/0/1", d_done, d_rdata, if_valid, stall); end
        next_cycle(); d_req = 0; m_ready = 0; #1;
        checks++; if (m_req !== 1'b0 || stall !== 1'b1 || d_done !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL prio_c2: m_req=%0b stall=%0b d_done=%0b d_rdata=%h want 0/1/0/deadbeef", m_req, stall, d_done, d_rdata); end
        next_cycle(); m_ready = 1; m_rdata = 32'h00A00113; #1;
        checks++; if (m_addr !== 32'h14 || if_valid !== 1'b1 || if_rdata !== 32'h00A00113 || stall !== 1'b0) begin
            errors++; $display("FAIL prio_c3: m_addr=%h if_valid=%0b if_rdata=%h stall=%0b want 14/1/00a00113/0", m_addr, if_valid, if_rdata, stall); end
        next_cycle(); if_req = 0; m_ready = 0;
        $display("priority: data then fetch, d_rdata=%h", d_rdata);
    endtask

    task automatic test_store();
        next_cycle(); d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); #1;
            checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h200 || m_wdata !== 32'h12345678 || d_done !== 1'b0) begin
                errors++; $display("FAIL store_wait%0d: m_req=%0b m_we=%0b m_addr=%h m_wdata=%h d_done=%0b", c, m_req, m_we, m_addr, m_wdata, d_done); end
        end
        next_cycle(); m_ready = 1; m_rdata = 32'hFFFFFFFF; #1;
        checks++; if (d_done !== 1'b1 || err !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_done: d_done=%0b err=%0b d_rdata=%h want 1/0/deadbeef", d_done, err, d_rdata); end
        next_cycle(); d_req = 0; d_we = 0; m_ready = 0; #1;
        checks++; if (m_req !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_after: m_req=%0b d_rdata=%h want 0/deadbeef", m_req, d_rdata); end
        $display("store: addr=0x200 data=12345678 complete");
    endtask

    task automatic test_watchdog();
        next_cycle(); d_req = 1; d_we = 0; d_addr = 32'h104;
        for (int c = 1; c <= 3; c++) begin
            next_cycle(); #1;
            checks++; if (err !== 1'b0 || d_done !== 1'b0 || m_req !== 1'b1) begin
                errors++; $display("FAIL wd_wait%0d: err=%0b d_done=%0b m_req=%0b want 0/0/1", c, err, d_done, m_req); end
        end
        next_cycle(); #1;
        checks++; if (err !== 1'b1 || d_done !== 1'b1 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL wd_abort: err=%0b d_done=%0b d_rdata=%h want 1/1/0", err, d_done, d_rdata); end
        next_cycle(); d_req = 0; #1;
        checks++; if (m_req !== 1'b0 || err !== 1'b0 || d_done !== 1'b0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL wd_after: m_req=%0b err=%0b d_done=%0b d_rdata=%h want 0/0/0/0", m_req, err, d_done, d_rdata); end
        $display("watchdog: read 0x104 aborted");
    endtask

    task automatic test_fbuf();
        next_cycle(); if_req = 1; if_addr = 32'h20;
        next_cycle(); m_ready = 1; m_rdata = 32'h00000297; #1;
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00000297) begin
            errors++; $display("FAIL fbuf_first: if_valid=%0b if_rdata=%h want 1/00000297", if_valid, if_rdata); end
        next_cycle(); if_req = 0; m_ready = 0;
        next_cycle(); if_req = 1; if_addr = 32'h20; #1;
`ifdef MEM_ARB_FBUF_EN
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00000297 || m_req !== 1'b0) begin
            errors++; $display("FAIL fbuf_hit: if_valid=%0b if_rdata=%h m_req=%0b want 1/00000297/0", if_valid, if_rdata, m_req); end
        next_cycle(); if_req = 0; #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fbuf_hit_idle: m_req=%0b want 0", m_req); end
`else
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fbuf_nobuf: if_valid=%0b want 0", if_valid); end
        next_cycle(); m_ready = 1; #1;
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h20 || if_valid !== 1'b1) begin
            errors++; $display("FAIL fbuf_refetch: m_req=%0b m_addr=%h if_valid=%0b want 1/20/1", m_req, m_addr, if_valid); end
        next_cycle(); if_req = 0; m_ready = 0;
`endif
        next_cycle(); d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h0;
        next_cycle(); m_ready = 1; #1;
        checks++; if (d_done !== 1'b1 || m_addr !== 32'h300) begin
            errors++; $display("FAIL fbuf_store: d_done=%0b m_addr=%h want 1/300", d_done, m_addr); end
        next_cycle(); d_req = 0; d_we = 0; m_ready = 0; if_req = 1; if_addr = 32'h20; #1;
        checks++; if (if_valid !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL fbuf_inval: if_valid=%0b stall=%0b want 0/1", if_valid, stall); end
        next_cycle(); m_ready = 1; m_rdata = 32'h00000297; #1;
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h20 || if_valid !== 1'b1) begin
            errors++; $display("FAIL fbuf_reissue: m_req=%0b m_addr=%h if_valid=%0b want 1/20/1", m_req, m_addr, if_valid); end
        next_cycle(); if_req = 0; m_ready = 0;
        $display("fbuf: fetch 0x20, store 0x300, refetch 0x20");
    endtask

    task automatic test_async_reset();
        next_cycle(); if_req = 1; if_addr = 32'h40;
        next_cycle();
        next_cycle(); #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL areset_pre: m_req=%0b want 1", m_req); end
        rst = 1'b0; #1;
        checks++; if (m_req !== 1'b0 || if_valid !== 1'b0 || if_rdata !== 32'h0) begin
            errors++; $display("FAIL areset_now: m_req=%0b if_valid=%0b if_rdata=%h want 0/0/0", m_req, if_valid, if_rdata); end
        next_cycle(); rst = 1'b1; #1;
        checks++; if (m_req !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL areset_idle: m_req=%0b stall=%0b want 0/1", m_req, stall); end
        next_cycle(); #1;
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0) begin
            errors++; $display("FAIL areset_restart: m_req=%0b m_addr=%h m_we=%0b want 1/40/0", m_req, m_addr, m_we); end
        m_ready = 1; m_rdata = 32'h00100073; #1;
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h00100073) begin
            errors++; $display("FAIL areset_done: if_valid=%0b if_rdata=%h want 1/00100073", if_valid, if_rdata); end
        next_cycle(); if_req = 0; m_ready = 0;
        $display("async_reset: fetch 0x40 restarted after reset");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_watchdog();
        test_fbuf();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
